// File: rtl/lcd_bus_arbiter.sv
// KS0108 LCD bus owner: power-up sequence, then round-robin
// arbitration of byte writes from two requesters into timed bus cycles.
module lcd_bus_arbiter #(
  parameter int RST_CYC   = 16,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       di0,
  input  logic       di1,
  input  logic [1:0] cs0,
  input  logic [1:0] cs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       ready,
  output logic       LCD_ENABLE,
  output logic       LCD_RW,
  output logic       LCD_DI,
  output logic       LCD_CS1,
  output logic       LCD_CS2,
  output logic       LCD_RST,
  output logic [7:0] LCD_DATA
);

  localparam int M0 = RST_CYC > SETUP_CYC ? RST_CYC : SETUP_CYC;
  localparam int M1 = EN_CYC > HOLD_CYC ? EN_CYC : HOLD_CYC;
  localparam int MX = M0 > M1 ? M0 : M1;
  localparam int CW = $clog2(MX + 1);

  typedef enum logic [2:0] {
    RST_HOLD, INIT, IDLE, SETUP, EN_HI, EN_LO, DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [1:0]    who, who_n;
  logic          last, last_n;
  logic          rdy, rdy_n;
  logic          di, di_n;
  logic [1:0]    cs, cs_n;
  logic [7:0]    dat, dat_n;
  logic          cnt_end;
  logic          bus;

  // init command table: {cs, data}
  function automatic logic [9:0] cmd(input logic [1:0] i);
    return {i[0] ? 2'b10 : 2'b01, i[1] ? 8'hC0 : 8'h3F};
  endfunction

  always_comb begin
    cnt_end = 1'b0;
    unique case (state)
      RST_HOLD: cnt_end = cnt == CW'(RST_CYC - 1);
      SETUP:    cnt_end = cnt == CW'(SETUP_CYC - 1);
      EN_HI:    cnt_end = cnt == CW'(EN_CYC - 1);
      EN_LO:    cnt_end = cnt == CW'(HOLD_CYC - 1);
      default:  cnt_end = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    idx_n   = idx;
    who_n   = who;
    last_n  = last;
    rdy_n   = rdy;
    di_n    = di;
    cs_n    = cs;
    dat_n   = dat;
    unique case (state)
      RST_HOLD: begin
        cnt_n = cnt_end ? '0 : cnt + CW'(1);
        if (cnt_end) state_n = INIT;
      end
      INIT: begin
        idx_n         = 2'd0;
        who_n         = 2'b00;
        di_n          = 1'b0;
        {cs_n, dat_n} = cmd(2'd0);
        state_n       = SETUP;
      end
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && (!req1 || last)) begin
            who_n  = 2'b01;
            last_n = 1'b0;
            di_n   = di0;
            cs_n   = cs0;
            dat_n  = data0;
          end else begin
            who_n  = 2'b10;
            last_n = 1'b1;
            di_n   = di1;
            cs_n   = cs1;
            dat_n  = data1;
          end
          state_n = SETUP;
        end
      end
      SETUP: begin
        cnt_n = cnt_end ? '0 : cnt + CW'(1);
        if (cnt_end) state_n = EN_HI;
      end
      EN_HI: begin
        cnt_n = cnt_end ? '0 : cnt + CW'(1);
        if (cnt_end) state_n = EN_LO;
      end
      EN_LO: begin
        cnt_n = cnt_end ? '0 : cnt + CW'(1);
        if (cnt_end) begin
          state_n = DONE;
          if (who == 2'b00 && idx == 2'd3) rdy_n = 1'b1;
        end
      end
      DONE: begin
        // init commands chain straight into the next bus cycle
        if (who == 2'b00 && idx != 2'd3) begin
          idx_n         = idx + 2'd1;
          {cs_n, dat_n} = cmd(idx + 2'd1);
          state_n       = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST_HOLD;
      cnt   <= '0;
      idx   <= 2'd0;
      who   <= 2'b00;
      last  <= 1'b1;
      rdy   <= 1'b0;
      di    <= 1'b0;
      cs    <= 2'b00;
      dat   <= 8'h00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      who   <= who_n;
      last  <= last_n;
      rdy   <= rdy_n;
      di    <= di_n;
      cs    <= cs_n;
      dat   <= dat_n;
    end
  end

  assign bus        = state == SETUP || state == EN_HI || state == EN_LO;
  assign LCD_ENABLE = state == EN_HI;
  assign LCD_RST    = state != RST_HOLD;
  assign LCD_RW     = 1'b0;
  assign LCD_DI     = di;
  assign LCD_CS1    = bus & cs[0];
  assign LCD_CS2    = bus & cs[1];
  assign LCD_DATA   = dat;
  assign ready      = rdy;
  assign ack0       = state == DONE && who == 2'b01;
  assign ack1       = state == DONE && who == 2'b10;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: power-up sequence, single writes,
// round-robin, cs=00, and reset during a strobe.
module tb_lcd_bus_arbiter;

  logic       clk, reset;
  logic       req0, req1, di0, di1;
  logic [1:0] cs0, cs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, ready;
  logic       LCD_ENABLE, LCD_RW, LCD_DI;
  logic       LCD_CS1, LCD_CS2, LCD_RST;
  logic [7:0] LCD_DATA;

  int total = 0;
  int bad   = 0;
  int cyc;

  logic [11:0] sb[$];
  logic [10:0] cap;
  int          en_cyc;
  logic        en_q;

  lcd_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .di0(di0), .di1(di1),
    .cs0(cs0), .cs1(cs1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .ready(ready),
    .LCD_ENABLE(LCD_ENABLE), .LCD_RW(LCD_RW),
    .LCD_DI(LCD_DI), .LCD_CS1(LCD_CS1),
    .LCD_CS2(LCD_CS2), .LCD_RST(LCD_RST),
    .LCD_DATA(LCD_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic w, input logic d,
                      input logic [1:0] c, input logic [7:0] v);
    sb.push_back({w, d, c, v});
  endtask

  // scoreboard side: fields seen on the strobe, checked at ack
  always @(negedge clk) begin
    logic [11:0] e;
    if (reset) begin
      en_q = 1'b0;
    end else begin
      if (LCD_ENABLE && !en_q && ready) begin
        cap    = {LCD_DI, LCD_CS2, LCD_CS1, LCD_DATA};
        en_cyc = cyc;
      end
      en_q = LCD_ENABLE;
      if (ack0 || ack1) begin
        chk("ack_one", 32'(ack0 & ack1), 0);
        chk("ack_rdy", 32'(ready), 1);
        chk("sb_has", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_item", 32'({ack1, cap}), 32'(e));
        end
        chk("ack_lat", cyc - en_cyc, 6);
      end
    end
  end

  task automatic wait_ack(input int lim, output int at);
    int ok = 0;
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        at = cyc;
        ok = 1;
        break;
      end
    end
    chk("ack_seen", ok, 1);
  endtask

  task automatic boot_check();
    int   rst_hi = -1;
    int   rdy = -1;
    int   np = 0;
    int   w = 0;
    int   ak = 0;
    logic pe = 1'b0;
    logic [10:0] f[4];
    int   wd[4];
    logic [10:0] exf[4];
    exf[0] = {1'b0, 2'b01, 8'h3F};
    exf[1] = {1'b0, 2'b10, 8'h3F};
    exf[2] = {1'b0, 2'b01, 8'hC0};
    exf[3] = {1'b0, 2'b10, 8'hC0};
    for (int i = 0; i < 4; i++) begin
      f[i]  = '0;
      wd[i] = 0;
    end
    for (int k = 0; k < 120 && rdy < 0; k++) begin
      if (LCD_RST && rst_hi < 0) rst_hi = cyc;
      if (ready && rdy < 0) rdy = cyc;
      if (ack0 || ack1) ak++;
      if (LCD_ENABLE && !pe && np < 4)
        f[np] = {LCD_DI, LCD_CS2, LCD_CS1, LCD_DATA};
      if (LCD_ENABLE) w++;
      if (!LCD_ENABLE && pe) begin
        if (np < 4) wd[np] = w;
        np++;
        w = 0;
      end
      pe = LCD_ENABLE;
      @(negedge clk);
    end
    chk("boot_rst", rst_hi, 16);
    chk("boot_rdy", rdy, 52);
    chk("boot_np", np, 4);
    chk("boot_ack", ak, 0);
    for (int i = 0; i < 4; i++) begin
      chk("boot_w", wd[i], 4);
      chk("boot_f", 32'(f[i]), 32'(exf[i]));
    end
  endtask

  initial begin
    int at, t, prev, ok;
    reset = 1'b1;
    req0 = 0; req1 = 0; di0 = 0; di1 = 0;
    cs0 = 0; cs1 = 0; data0 = 0; data1 = 0;
    #1;
    chk("r_lcdrst", 32'(LCD_RST), 0);
    chk("r_en", 32'(LCD_ENABLE), 0);
    chk("r_rdy", 32'(ready), 0);
    chk("r_ack", 32'({ack0, ack1}), 0);
    chk("r_bus", 32'({LCD_RW, LCD_DI, LCD_CS1,
                      LCD_CS2, LCD_DATA}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    boot_check();

    // single data write to left half
    di0 = 1; cs0 = 2'b01; data0 = 8'hA5;
    push(0, 1, 2'b01, 8'hA5);
    t = cyc;
    req0 = 1;
    wait_ack(30, at);
    req0 = 0;
    chk("s2_lat", at - t, 9);
    repeat (2) @(negedge clk);

    // no half selected: still strobed and acked
    di0 = 0; cs0 = 2'b00; data0 = 8'h3C;
    push(0, 0, 2'b00, 8'h3C);
    t = cyc;
    req0 = 1;
    wait_ack(30, at);
    req0 = 0;
    chk("s5_lat", at - t, 9);
    repeat (2) @(negedge clk);

    // lone requester 1, three back-to-back writes
    di1 = 0; cs1 = 2'b11; data1 = 8'h60;
    for (int k = 0; k < 3; k++) push(1, 0, 2'b11, 8'(8'h60 + k));
    req1 = 1;
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(30, at);
      if (k > 0) chk("s4_gap", at - prev, 10);
      prev = at;
      data1 = data1 + 8'd1;
    end
    req1 = 0;
    repeat (2) @(negedge clk);

    // fresh reset: req0 wins the first tie, then alternation
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    boot_check();
    di0 = 0; cs0 = 2'b01; data0 = 8'h20;
    di1 = 1; cs1 = 2'b10; data1 = 8'h10;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(0, 0, 2'b01, 8'(8'h20 + k / 2));
      else            push(1, 1, 2'b10, 8'(8'h10 + k / 2));
    end
    req0 = 1; req1 = 1;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(30, at);
      if (k > 0) chk("s3_gap", at - prev, 10);
      prev = at;
      if (ack0) data0 = data0 + 8'd1;
      else      data1 = data1 + 8'd1;
    end
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);

    // reset while the strobe is high
    di0 = 1; cs0 = 2'b11; data0 = 8'h5A;
    req0 = 1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (LCD_ENABLE) begin
        ok = 1;
        break;
      end
    end
    chk("s6_en", ok, 1);
    reset = 1'b1;
    #1;
    chk("s6_enz", 32'(LCD_ENABLE), 0);
    chk("s6_rst", 32'(LCD_RST), 0);
    chk("s6_rdy", 32'(ready), 0);
    chk("s6_ack", 32'({ack0, ack1}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    boot_check();
    push(0, 1, 2'b11, 8'h5A);
    wait_ack(30, at);
    req0 = 0;
    chk("s6_at", at, 62);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
